apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
APB initiator (requester) that converts a simple valid/ready command stream into single APB transfers.
- Drives the master side of the team's APB interface: 3-bit paddr, 16-bit pwdata/prdata.
- Returns read data or write completion on a valid/ready response channel.
- Sits between the test/control logic and the APB slave register block of the matrix multiplier.
- Flags slaves that stall too long (pready held low) via a sticky timeout status bit.

Parameters:
ADDR_W, 3, APB address width (paddr, cmd_addr)
DATA_W, 16, APB data width (pwdata, prdata, cmd_wdata, rsp_rdata)
TIMEOUT, 16, wait-state count that sets timeout_flag; 0 disables the check

Ports:
pclk  in  1  clock, all logic on rising edge
preset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_write  out  1  echo of cmd_write for this response
rsp_rdata  out  DATA_W  prdata captured on read completion; 0 for writes
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pready  in  1  APB slave ready
prdata  in  DATA_W  APB read data
timeout_flag  out  1  sticky: some transfer waited >= TIMEOUT cycles
clr_timeout  in  1  synchronous clear of timeout_flag
busy  out  1  high in SETUP or ACCESS

Behaviour:
- Reset (async, preset_n=0): state=IDLE. All outputs 0: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_write, rsp_rdata, timeout_flag, busy, wait counter. Reset mid-transfer drops psel/penable immediately and discards the transfer; no response is produced.
- States:
  - IDLE: cmd_ready = !rsp_valid || rsp_ready. On accept, register paddr<=cmd_addr, pwrite<=cmd_write, pwdata<=(cmd_write ? cmd_wdata : 0); go to SETUP.
  - SETUP: psel=1, penable=0; always go to ACCESS next cycle.
  - ACCESS: psel=1, penable=1. pready=0: stay and increment the wait counter. pready=1: complete. On completion set rsp_valid<=1, rsp_write<=pwrite, rsp_rdata<=(pwrite ? 0 : prdata), clear the wait counter, go to IDLE.
- psel and penable are registered outputs. cmd_ready is combinational from state and response occupancy.
- paddr, pwrite and pwdata are stable from SETUP through the final ACCESS cycle. They hold their last values in IDLE and change only on command accept.
- Minimum of 3 cycles per transfer: accept, SETUP, ACCESS. No back-to-back ACCESS→SETUP.
- Response register: rsp_valid clears on rsp_ready when no new completion arrives. Response fields are held stable while rsp_valid && !rsp_ready. A new command cannot be accepted while the response is blocked, so no response is ever overwritten.
- Simultaneous events:
  - rsp_ready and command accept in the same IDLE cycle: both proceed.
- Wait counter:
  - Width $clog2(TIMEOUT+1); saturates at TIMEOUT.
  - timeout_flag sets in the cycle the count reaches TIMEOUT, while the transfer continues normally (no APB abort).
  - clr_timeout clears the flag. If set and clear occur in the same cycle, set wins.
  - TIMEOUT=0: flag never sets.
- busy = (state==SETUP) || (state==ACCESS).

Decomposition:
- Shared package apb_pkg holds:
  - APB_ADDR_W=3 and APB_DATA_W=16 constants
  - typedef enum apb_mst_state_e {IDLE, SETUP, ACCESS}
  - packed struct apb_cmd_t {write, addr, wdata}
- One natural sub-module, apb_wait_timer: saturating wait counter plus sticky flag with set-over-clear priority. Everything else stays in apb_cmd_master.

Test Plan:
- Zero-wait write: addr=3, wdata=0x1234, pready tied 1.
  - Required: SETUP at cycle 1, ACCESS at cycle 2, rsp_valid=1 at cycle 3 with rsp_write=1, rsp_rdata=0.
  - paddr=3 and pwdata=0x1234 stable over cycles 1-2.
- Read with 3 wait states: addr=5, slave returns prdata=0xBEEF with pready after 3 low cycles.
  - Required: penable=1 for 4 cycles, rsp_rdata=0xBEEF, rsp_write=0, timeout_flag=0.
- Response backpressure: rsp_ready=0 for 5 cycles after a read completes while cmd_valid=1.
  - Required: cmd_ready=0 and psel=0 throughout, rsp_rdata held.
  - rsp_ready=1 → same-cycle command accept, next SETUP follows.
- Timeout with TIMEOUT=4: pready low for 6 ACCESS cycles.
  - Required: timeout_flag=1 from the 4th wait cycle, transfer still completes normally.
  - clr_timeout pulse clears the flag; clr_timeout asserted in the same cycle as a new set leaves flag=1.
- Reset mid-ACCESS: preset_n low during a pending read.
  - Required: psel=penable=rsp_valid=busy=0 immediately with no response.
  - After release, a new write completes with normal 3-cycle timing.
- Back-to-back stream of 4 alternating write/read commands, rsp_ready=1.
  - Required: 4 responses in order, psel low exactly 1 cycle between transfers, no paddr change during any SETUP/ACCESS.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, initiator state encoding and the command bundle.
package apb_pkg;

    localparam int APB_ADDR_W = 3;
    localparam int APB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating APB wait-state counter with a sticky timeout flag; a set in the
// same cycle as a clear keeps the flag high.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic wait_cyc,
    input  logic done,
    input  logic clr_flag,
    output logic timeout_flag
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SET = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic             set_flag;

    // The flag is raised on the wait cycle that carries the count onto TIMEOUT.
    assign set_flag = (TIMEOUT != 0) && wait_cyc && (cnt == CNT_SET);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt <= '0;
        end else if (done) begin
            cnt <= '0;
        end else if (wait_cyc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            timeout_flag <= 1'b0;
        end else if (set_flag) begin
            timeout_flag <= 1'b1;
        end else if (clr_flag) begin
            timeout_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// APB initiator: turns a valid/ready command stream into single APB transfers
// and returns write completions or read data on a valid/ready response channel.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    output logic              timeout_flag,
    input  logic              clr_timeout,
    output logic              busy
);

    apb_mst_state_e state, state_nxt;
    logic           accept;
    logic           complete;
    logic           wait_cyc;

    // Commands are only taken when the response slot is free or draining this
    // cycle, so a finished transfer can never overwrite an unread response.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        complete  = 1'b0;
        wait_cyc  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = !rsp_valid || rsp_ready;
                accept    = cmd_valid && (!rsp_valid || rsp_ready);
                if (accept) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cyc = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
        end else begin
            state   <= state_nxt;
            psel    <= (state_nxt != IDLE);
            penable <= (state_nxt == ACCESS);
        end
    end

    // Address phase fields change only on accept and hold through IDLE.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
        end else if (accept) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_write ? cmd_wdata : '0;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else if (complete) begin
            rsp_valid <= 1'b1;
            rsp_write <= pwrite;
            rsp_rdata <= pwrite ? '0 : prdata;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign busy = (state == SETUP) || (state == ACCESS);

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk         (pclk),
        .preset_n     (preset_n),
        .wait_cyc     (wait_cyc),
        .done         (complete),
        .clr_flag     (clr_timeout),
        .timeout_flag (timeout_flag)
    );

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed transfers against a small APB slave, with a
// response scoreboard and per-cycle protocol checks running alongside.
module tb_apb_cmd_master;
    import apb_pkg::*;

    localparam int TO = 4;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [15:0] rsp_rdata;
    logic [2:0]  paddr;
    logic        psel, penable, pwrite, pready;
    logic [15:0] pwdata, prdata;
    logic        timeout_flag, clr_timeout, busy;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int nrsp = 0;
    int acc_cnt;
    int wait_n = 0;

    logic [15:0] smem [8];

    typedef struct packed {
        logic        w;
        logic [15:0] d;
    } rsp_t;
    rsp_t expq[$];

    always #5 pclk = ~pclk;

    apb_cmd_master #(
        .ADDR_W  (3),
        .DATA_W  (16),
        .TIMEOUT (TO)
    ) dut (
        .pclk         (pclk),
        .preset_n     (preset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_write    (rsp_write),
        .rsp_rdata    (rsp_rdata),
        .paddr        (paddr),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .pwdata       (pwdata),
        .pready       (pready),
        .prdata       (prdata),
        .timeout_flag (timeout_flag),
        .clr_timeout  (clr_timeout),
        .busy         (busy)
    );

    function automatic logic [15:0] init_val(int i);
        if (i == 5) return 16'hBEEF;
        return 16'h0A00 + 16'(i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Slave: inserts wait_n wait states per transfer, returns smem contents.
    assign pready = psel && penable && (acc_cnt >= wait_n);
    assign prdata = pready ? smem[paddr] : 16'hDEAD;

    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) acc_cnt <= 0;
        else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 8; i++) smem[i] <= init_val(i);
        forever begin
            @(posedge pclk);
            if (preset_n && psel && penable && pready && pwrite) smem[paddr] <= pwdata;
        end
    end

    // Scoreboard and protocol monitor.
    initial begin
        logic        pp, hv, hw;
        logic [15:0] hd;
        apb_cmd_t    cur;
        rsp_t        e;
        logic [15:0] mm [8];
        for (int i = 0; i < 8; i++) mm[i] = init_val(i);
        pp = 1'b0; hv = 1'b0; hw = 1'b0; hd = '0; cur = '0;
        forever begin
            @(negedge pclk);
            if (!preset_n) begin
                expq.delete();
                pp = 1'b0;
                hv = 1'b0;
            end else begin
                chk("busy_vs_psel", 32'(busy), 32'(psel));
                chk("cmd_ready_rule", 32'(cmd_ready), 32'(!psel && (!rsp_valid || rsp_ready)));
                if (psel) begin
                    chk("penable_phase", 32'(penable), 32'(pp));
                    chk("paddr_stable", 32'(paddr), 32'(cur.addr));
                    chk("pwrite_stable", 32'(pwrite), 32'(cur.write));
                    chk("pwdata_stable", 32'(pwdata), 32'(cur.write ? cur.wdata : 16'h0));
                end else begin
                    chk("penable_idle", 32'(penable), 32'(0));
                end
                if (hv) begin
                    chk("rsp_hold_valid", 32'(rsp_valid), 32'(1));
                    chk("rsp_hold_write", 32'(rsp_write), 32'(hw));
                    chk("rsp_hold_rdata", 32'(rsp_rdata), 32'(hd));
                end
                if (rsp_valid && rsp_ready) begin
                    chk("rsp_expected", 32'(expq.size() != 0), 32'(1));
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        chk("rsp_write", 32'(rsp_write), 32'(e.w));
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.d));
                        nrsp++;
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    cur.write = cmd_write;
                    cur.addr  = cmd_addr;
                    cur.wdata = cmd_wdata;
                    e.w = cmd_write;
                    e.d = cmd_write ? 16'h0 : mm[cmd_addr];
                    expq.push_back(e);
                    if (cmd_write) mm[cmd_addr] = cmd_wdata;
                end
                pp = psel;
                hv = rsp_valid && !rsp_ready;
                hw = rsp_write;
                hd = rsp_rdata;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic issue(input logic w, input logic [2:0] a, input logic [15:0] d,
                         output int acc_cyc);
        bit ok;
        ok = 1'b0;
        acc_cyc = -1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge pclk);
            if (cmd_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!ok) chk("cmd_accept", 32'(0), 32'(1));
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int npen);
        bit seen;
        seen = 1'b0;
        npen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge pclk);
            if (penable) npen++;
            if (rsp_valid) seen = 1'b1;
        end
        if (!seen) chk("rsp_arrival", 32'(0), 32'(1));
    endtask

    task automatic zero_wait_write(input logic [2:0] a, input logic [15:0] d);
        int ac;
        issue(1'b1, a, d, ac);
        @(negedge pclk);
        chk("zw_setup_psel", 32'(psel), 32'(1));
        chk("zw_setup_penable", 32'(penable), 32'(0));
        chk("zw_setup_paddr", 32'(paddr), 32'(a));
        chk("zw_setup_pwdata", 32'(pwdata), 32'(d));
        @(negedge pclk);
        chk("zw_access_penable", 32'(penable), 32'(1));
        chk("zw_access_paddr", 32'(paddr), 32'(a));
        chk("zw_access_pwdata", 32'(pwdata), 32'(d));
        @(negedge pclk);
        chk("zw_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("zw_rsp_write", 32'(rsp_write), 32'(1));
        chk("zw_rsp_rdata", 32'(rsp_rdata), 32'(0));
        chk("zw_rsp_psel", 32'(psel), 32'(0));
    endtask

    initial begin
        int ac, a0, a1, a2, a3, np, n0;
        preset_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; clr_timeout = 1'b0; wait_n = 0;

        #12;
        chk("rst_psel", 32'(psel), 32'(0));
        chk("rst_penable", 32'(penable), 32'(0));
        chk("rst_pwrite", 32'(pwrite), 32'(0));
        chk("rst_paddr", 32'(paddr), 32'(0));
        chk("rst_pwdata", 32'(pwdata), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_write", 32'(rsp_write), 32'(0));
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        chk("rst_timeout_flag", 32'(timeout_flag), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        @(posedge pclk); #1;
        preset_n = 1'b1;
        @(posedge pclk); #1;

        // Zero-wait write.
        zero_wait_write(3'd3, 16'h1234);
        @(posedge pclk); #1;

        // Read with three wait states.
        wait_n = 3;
        issue(1'b0, 3'd5, 16'h0, ac);
        wait_rsp(np);
        chk("rd3_penable_cycles", 32'(np), 32'(4));
        chk("rd3_rsp_rdata", 32'(rsp_rdata), 32'(16'hBEEF));
        chk("rd3_rsp_write", 32'(rsp_write), 32'(0));
        chk("rd3_timeout_flag", 32'(timeout_flag), 32'(0));
        @(posedge pclk); #1;

        // Response backpressure with a command waiting.
        wait_n = 0;
        rsp_ready = 1'b0;
        issue(1'b0, 3'd5, 16'h0, ac);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd2; cmd_wdata = 16'h55AA;
        wait_rsp(np);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge pclk);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'(0));
            chk("bp_psel", 32'(psel), 32'(0));
            chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("bp_rsp_rdata", 32'(rsp_rdata), 32'(16'hBEEF));
        end
        @(posedge pclk); #1;
        rsp_ready = 1'b1;
        @(negedge pclk);
        chk("bp_release_accept", 32'(cmd_ready), 32'(1));
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk("bp_next_setup_psel", 32'(psel), 32'(1));
        chk("bp_next_setup_penable", 32'(penable), 32'(0));
        chk("bp_next_setup_paddr", 32'(paddr), 32'(2));
        wait_rsp(np);
        @(posedge pclk); #1;

        // Timeout: six wait states against TIMEOUT=4.
        wait_n = 6;
        issue(1'b0, 3'd0, 16'h0, ac);
        @(negedge pclk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge pclk);
            chk("to_penable", 32'(penable), 32'(1));
            chk("to_flag", 32'(timeout_flag), 32'(k >= 5));
        end
        @(negedge pclk);
        chk("to_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("to_rsp_rdata", 32'(rsp_rdata), 32'(16'h0A00));
        chk("to_flag_after", 32'(timeout_flag), 32'(1));
        @(posedge pclk); #1;
        clr_timeout = 1'b1;
        @(posedge pclk); #1;
        clr_timeout = 1'b0;
        @(negedge pclk);
        chk("to_flag_cleared", 32'(timeout_flag), 32'(0));
        @(posedge pclk); #1;
        issue(1'b0, 3'd0, 16'h0, ac);
        repeat (4) @(posedge pclk);
        #1;
        clr_timeout = 1'b1;
        @(posedge pclk); #1;
        clr_timeout = 1'b0;
        @(negedge pclk);
        chk("to_set_over_clear", 32'(timeout_flag), 32'(1));
        wait_rsp(np);
        @(posedge pclk); #1;

        // Reset while a read is stalled in ACCESS.
        wait_n = 10;
        issue(1'b0, 3'd1, 16'h0, ac);
        @(posedge pclk); #1;
        @(posedge pclk); #3;
        preset_n = 1'b0;
        #1;
        chk("mid_rst_psel", 32'(psel), 32'(0));
        chk("mid_rst_penable", 32'(penable), 32'(0));
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_flag", 32'(timeout_flag), 32'(0));
        @(posedge pclk); #1;
        preset_n = 1'b1;
        wait_n = 0;
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        zero_wait_write(3'd6, 16'h0F0F);
        @(posedge pclk); #1;

        // Back-to-back alternating stream.
        n0 = nrsp;
        issue(1'b1, 3'd4, 16'h1111, a0);
        issue(1'b0, 3'd4, 16'h0, a1);
        issue(1'b1, 3'd7, 16'h7777, a2);
        issue(1'b0, 3'd7, 16'h0, a3);
        chk("stream_gap_1", 32'(a1 - a0), 32'(3));
        chk("stream_gap_2", 32'(a2 - a1), 32'(3));
        chk("stream_gap_3", 32'(a3 - a2), 32'(3));
        repeat (4) @(negedge pclk);
        chk("stream_rsp_count", 32'(nrsp - n0), 32'(4));
        chk("scoreboard_drained", 32'(expq.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
